// File: rtl/register_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : register_pkg
//  Description : Shared constants and the byte-lane merge helper for the
//                register file and its per-entry byte-enable register.
//  Revision    : 1.0  initial release
// ============================================================================
package register_pkg;

    localparam int REG_WIDTH = 32;
    localparam int REG_DEPTH = 16;

    // One byte lane of a masked merge: the new byte when its enable is set,
    // otherwise the old byte. Callers loop over lanes so any WIDTH works.
    function automatic logic [7:0] byte_merge(
        input logic [7:0] old_byte,
        input logic [7:0] new_byte,
        input logic       mask
    );
        return mask ? new_byte : old_byte;
    endfunction

endpackage : register_pkg
`default_nettype wire

// File: rtl/register_be.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : register_be
//  Description : Single WIDTH-bit register with synchronous clear and
//                byte-enabled write. Clear takes priority over Write.
//  Revision    : 1.0  initial release
// ============================================================================
module register_be
    import register_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH
) (
    input  logic               Clock,
    input  logic               Clear,
    input  logic               Write,
    input  logic [WIDTH/8-1:0] Mask,
    input  logic [WIDTH-1:0]   D,
    output logic [WIDTH-1:0]   Q
);

    localparam int c_LANES = WIDTH / 8;

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next value if written: enabled lanes take D, the rest hold.
    always_comb begin
        data_d = data_q;
        for (int i = 0; i < c_LANES; i++) begin
            data_d[8*i +: 8] = byte_merge(data_q[8*i +: 8], D[8*i +: 8], Mask[i]);
        end
    end

    // Storage update with clear overriding any write in the same cycle.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            data_q <= '0;
        end else if (Write) begin
            data_q <= data_d;
        end
    end

    assign Q = data_q;

endmodule : register_be
`default_nettype wire

// File: rtl/register_file.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : register_file
//  Description : DEPTH x WIDTH register file, one byte-masked write port,
//                two independent read ports, optional hardwired-zero entry 0,
//                optional write-to-read bypass, optional registered reads.
//  Revision    : 1.0  initial release
// ============================================================================
module register_file
    import register_pkg::*;
#(
    parameter  int WIDTH    = REG_WIDTH,
    parameter  int DEPTH    = REG_DEPTH,
    parameter  bit ZERO_REG = 1'b1,
    parameter  bit BYPASS   = 1'b1,
    parameter  bit REG_READ = 1'b0,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic               Clock,
    input  logic               Clear,
    input  logic               Write,
    input  logic [ADDR_W-1:0]  WriteAddr,
    input  logic [WIDTH-1:0]   WriteData,
    input  logic [WIDTH/8-1:0] WriteMask,
    input  logic [ADDR_W-1:0]  ReadAddrA,
    input  logic [ADDR_W-1:0]  ReadAddrB,
    output logic [WIDTH-1:0]   QA,
    output logic [WIDTH-1:0]   QB
);

    localparam int                c_LANES = WIDTH / 8;
    // DEPTH held one bit wider than the address so DEPTH = 2**ADDR_W fits.
    localparam logic [ADDR_W:0]   c_DEPTH = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]  w_entry [DEPTH];
    logic [ADDR_W-1:0] w_raddr [2];
    logic [WIDTH-1:0]  w_rdata [2];
    logic              w_wr_legal;

    assign w_raddr[0] = ReadAddrA;
    assign w_raddr[1] = ReadAddrB;

    // A write that will actually land somewhere; only such writes may bypass.
    assign w_wr_legal = Write && !Clear
                     && ({1'b0, WriteAddr} < c_DEPTH)
                     && !(ZERO_REG && (WriteAddr == '0));

    // ------------------------------------------------------------------
    // Storage: one byte-enabled register per entry; entry 0 is a constant
    // zero when ZERO_REG is set. Out-of-range write addresses match no
    // entry and are therefore dropped.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        if (ZERO_REG && (gi == 0)) begin : g_zero
            assign w_entry[gi] = '0;
        end else begin : g_reg
            logic w_we;
            assign w_we = Write && (WriteAddr == ADDR_W'(gi));
            register_be #(
                .WIDTH (WIDTH)
            ) u_reg (
                .Clock (Clock),
                .Clear (Clear),
                .Write (w_we),
                .Mask  (WriteMask),
                .D     (WriteData),
                .Q     (w_entry[gi])
            );
        end
    end

    // ------------------------------------------------------------------
    // Read ports: each applies range check and bypass independently.
    // ------------------------------------------------------------------
    for (genvar gp = 0; gp < 2; gp++) begin : g_port
        logic [WIDTH-1:0] w_base;
        logic             w_hit;

        // Base value (0 when out of range) merged with a same-cycle write.
        always_comb begin
            w_base = '0;
            if ({1'b0, w_raddr[gp]} < c_DEPTH) begin
                w_base = w_entry[w_raddr[gp]];
            end
            w_hit = BYPASS && w_wr_legal && (WriteAddr == w_raddr[gp]);
            w_rdata[gp] = w_base;
            if (w_hit) begin
                for (int i = 0; i < c_LANES; i++) begin
                    w_rdata[gp][8*i +: 8] = byte_merge(w_base[8*i +: 8],
                                                       WriteData[8*i +: 8],
                                                       WriteMask[i]);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output stage: registered or combinational read data.
    // ------------------------------------------------------------------
    if (REG_READ) begin : g_reg_read
        logic [WIDTH-1:0] qa_q;
        logic [WIDTH-1:0] qb_q;

        // Capture the read values every edge; cleared alongside storage.
        always_ff @(posedge Clock) begin
            if (Clear) begin
                qa_q <= '0;
                qb_q <= '0;
            end else begin
                qa_q <= w_rdata[0];
                qb_q <= w_rdata[1];
            end
        end

        assign QA = qa_q;
        assign QB = qb_q;
    end else begin : g_comb_read
        assign QA = w_rdata[0];
        assign QB = w_rdata[1];
    end

endmodule : register_file
`default_nettype wire
